// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A-B, LSB first, one bit per clock behind a start/done handshake
//   clk_i, rst_i (sync, active-high), start_i, a_i/b_i (operands)
//   busy_o, done_o (one-cycle pulse), diff_o, borrow_o, zero_o (held until next completion)
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] diff_o,
   output logic             borrow_o,
   output logic             zero_o
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_sa, r_sb, r_sd;
   logic             r_br;
   logic [CW-1:0]    r_cnt;
   logic             w_d, w_br, w_load, w_last;
   logic [WIDTH-1:0] w_sd;
   assign w_d    = r_sa[0] ^ r_sb[0] ^ r_br;
   assign w_br   = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
   assign w_load = start_i && r_state != BUSY;
   assign w_last = r_cnt == CW'(WIDTH - 1);
   // a one-bit result register has no upper bits to shift down
   if (WIDTH == 1) begin : g_w1
      assign w_sd = w_d;
   end else begin : g_wn
      assign w_sd = {w_d, r_sd[WIDTH-1:1]};
   end
   assign busy_o = r_state == BUSY;
   assign done_o = r_state == DONE;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= IDLE;
         r_sa     <= '0;
         r_sb     <= '0;
         r_sd     <= '0;
         r_br     <= 1'b0;
         r_cnt    <= '0;
         diff_o   <= '0;
         borrow_o <= 1'b0;
         zero_o   <= 1'b1;
      end else if (w_load) begin
         r_state <= BUSY;
         r_sa    <= a_i;
         r_sb    <= b_i;
         r_sd    <= '0;
         r_br    <= 1'b0;
         r_cnt   <= '0;
      end else if (r_state == BUSY) begin
         r_sa  <= r_sa >> 1;
         r_sb  <= r_sb >> 1;
         r_sd  <= w_sd;
         r_br  <= w_br;
         r_cnt <= r_cnt + 1'b1;
         if (w_last) begin
            r_state  <= DONE;
            diff_o   <= w_sd;
            borrow_o <= w_br;
            zero_o   <= w_sd == '0;
         end
      end else begin
         r_state <= IDLE;
      end
   end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement/unsigned subtractor that computes A − B one bit per clock, LSB first, using a single registered borrow bit. It is the subtract-direction companion to the team's structural 1-bit full adder and ripple adder. It trades area for latency in datapaths where a full-width ripple subtractor is not justified. It sits behind a simple start/done handshake driven by a controlling FSM.

## Interface

- WIDTH, 8, operand and result width in bits; legal range WIDTH ≥ 1.
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  request; sampled only in IDLE or DONE.
- a_i  input  WIDTH  minuend; captured on the accepting edge.
- b_i  input  WIDTH  subtrahend; captured on the accepting edge.
- busy_o  output  1  high while in BUSY.
- done_o  output  1  one-cycle pulse; result valid.
- diff_o  output  WIDTH  A − B modulo 2^WIDTH; held until next completion.
- borrow_o  output  1  final borrow-out (1 ⇔ A < B unsigned); held with diff_o.
- zero_o  output  1  1 ⇔ diff_o == 0; held with diff_o.

## Operation

- Internal state: FSM {IDLE, BUSY, DONE}; shift registers sa, sb, sd (WIDTH each); borrow register br; bit counter cnt, clog2(WIDTH+1) bits.
- IDLE: on start_i=1, load sa←a_i, sb←b_i, br←0, cnt←0, sd←0; go BUSY. Otherwise stay.
- BUSY, every cycle:
  - d = sa[0] ^ sb[0] ^ br.
  - br ← (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br).
  - sd ← {d, sd[WIDTH-1:1]}; sa, sb shift right by one; cnt ← cnt+1.
  - When cnt == WIDTH−1: also load diff_o ← {d, sd[WIDTH-1:1]}, borrow_o ← new br, zero_o ← (that value == 0); go DONE.
  - start_i ignored in BUSY; a_i/b_i changes have no effect after capture.
- DONE: done_o=1 for this cycle. If start_i=1, load operands exactly as in IDLE and go BUSY (back-to-back). Otherwise go IDLE.
- diff_o, borrow_o and zero_o change only on the BUSY→DONE edge. Otherwise they hold their previous values indefinitely.
- Arithmetic: result equals (a_i − b_i) mod 2^WIDTH. borrow_o is the unsigned borrow. Signed overflow is not reported.
- WIDTH=1: BUSY lasts exactly one cycle.

## Timing

- Reset, on any edge with rst_i=1 and taking priority over everything:
  - FSM to IDLE.
  - busy_o=0, done_o=0, diff_o=0, borrow_o=0, zero_o=1.
  - Internal registers and cnt cleared.
- Reset mid-operation abandons the operation with no done_o pulse. Outputs take their reset values.
- Accepting edge E (start_i=1 in IDLE/DONE): busy_o=1 from E through E+WIDTH−1.
- Edge E+WIDTH: done_o=1 and results valid for exactly one cycle. busy_o=0.
- Latency is WIDTH cycles from the accepting edge to the done_o cycle.
- Back-to-back throughput is one operation per WIDTH+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- WIDTH=8, a=0x5A, b=0x3C, start one cycle → done_o pulse exactly 8 cycles after accept; diff_o=0x1E, borrow_o=0, zero_o=0.
- WIDTH=8, a=0x00, b=0x01 → diff_o=0xFF, borrow_o=1, zero_o=0. Then a=0x80, b=0x80 → diff_o=0x00, borrow_o=0, zero_o=1.
- Hold start_i=1 continuously with a=0x10, b=0x01, then a=0x03, b=0x05 → done_o pulses every 9 cycles. Results are 0x0F/borrow 0, then 0xFE/borrow 1.
- Toggle start_i and change a_i/b_i during BUSY → no restart; result reflects the originally captured operands; done_o timing unchanged.
- Assert rst_i for one cycle at the 4th BUSY cycle → no done_o pulse; all outputs at reset values (zero_o=1); a subsequent start yields a correct result.
- WIDTH=1 instance, all four (a,b) combinations → done_o 1 cycle after accept. (0,1) gives diff 1/borrow 1; (1,0) gives 1/0; (1,1) gives 0/0 with zero 1.
